// File: rtl/period_meter.sv
// Purpose: measures period and high time of a slow asynchronous square wave, in clk_in cycles.
// Latency: a result is presented SYNC_STAGES edges after the closing rise is first sampled.
// Backpressure: one-entry result register; a capture into an unaccepted result is dropped and flags overrun.
module period_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1000000
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             overrun,
  output logic             stalled
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE
  } state_e;

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W    = '0;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic                   valid_q, valid_d;
  logic [WIDTH-1:0]       per_q, per_d;
  logic [WIDTH-1:0]       ht_q, ht_d;
  logic                   ovr_q, ovr_d;
  logic                   stall_q, stall_d;
  logic                   capture;

  logic s;
  logic rise;
  logic xfer;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign xfer = valid_q & meas_ready;

  assign meas_valid = valid_q;
  assign period     = per_q;
  assign high_time  = ht_q;
  assign overrun    = ovr_q;
  assign stalled    = stall_q;

  // Synchronizer chain plus one-cycle delayed copy of its output for edge detection.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
    end
  end

  // State, counters and the result register.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      valid_q <= 1'b0;
      per_q   <= '0;
      ht_q    <= '0;
      ovr_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      valid_q <= valid_d;
      per_q   <= per_d;
      ht_q    <= ht_d;
      ovr_q   <= ovr_d;
      stall_q <= stall_d;
    end
  end

  // Next-state: enable=0 wins over everything; a rise wins over the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    valid_d = valid_q;
    per_d   = per_q;
    ht_d    = ht_q;
    ovr_d   = ovr_q;
    stall_d = stall_q;
    capture = 1'b0;

    // An accepted result leaves the register unless a capture refills it below.
    if (xfer) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d   = ZERO_W;
        hi_d    = ZERO_W;
        valid_d = 1'b0;
        ovr_d   = 1'b0;
        stall_d = 1'b0;
        if (enable) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (rise) begin
          cnt_d   = ONE_W;
          hi_d    = ONE_W;
          stall_d = 1'b0;
          state_d = S_MEASURE;
        end else if (cnt_q == TIMEOUT_W) begin
          stall_d = 1'b1;
          cnt_d   = ZERO_W;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
      S_MEASURE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (rise) begin
          // The rise cycle itself is the first (high) cycle of the next period.
          capture = 1'b1;
          cnt_d   = ONE_W;
          hi_d    = ONE_W;
          stall_d = 1'b0;
        end else if (cnt_q == TIMEOUT_W) begin
          stall_d = 1'b1;
          cnt_d   = ZERO_W;
          state_d = S_ARM;
        end else begin
          cnt_d = cnt_q + ONE_W;
          hi_d  = hi_q + {{(WIDTH-1){1'b0}}, s};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Load only into an empty or just-accepted register; otherwise keep the old result.
    if (capture) begin
      if (!valid_q || xfer) begin
        per_d   = cnt_q;
        ht_d    = hi_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

  localparam int W  = 32;
  localparam int TO = 100;

  logic         clk_in;
  logic         reset_n;
  logic         enable;
  logic         sig_in;
  logic         meas_ready;
  logic         meas_valid;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         overrun;
  logic         stalled;

  period_meter #(
    .WIDTH      (W),
    .SYNC_STAGES(2),
    .TIMEOUT    (TO)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .sig_in    (sig_in),
    .meas_ready(meas_ready),
    .meas_valid(meas_valid),
    .period    (period),
    .high_time (high_time),
    .overrun   (overrun),
    .stalled   (stalled)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] per;
    logic [31:0] hi;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_xfer = 0;

  // Waveform model: samples since the last issued rise and how many of them were high.
  int   m_cnt = 0;
  int   m_hi = 0;
  bit   m_have = 0;
  bit   m_prev_push = 0;
  bit   push_en = 1;
  logic m_last = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic push_exp(input int per, input int hi, input int gap);
    exp_t e;
    e.per = per;
    e.hi  = hi;
    e.gap = gap;
    q.push_back(e);
  endtask

  // Drive one sample slot; a low-to-high change closes the previous period in the model.
  task automatic drv(input logic v);
    bit pushed;
    pushed = 0;
    if (v && !m_last) begin
      if (m_have && push_en) begin
        push_exp(m_cnt, m_hi, m_prev_push ? m_cnt : 0);
        pushed = 1;
      end
      m_prev_push = pushed;
      m_cnt  = 0;
      m_hi   = 0;
      m_have = 1;
    end
    m_cnt++;
    if (v) m_hi++;
    m_last = v;
    sig_in = v;
    @(posedge clk_in);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) drv(m_last);
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      repeat (h) drv(1'b1);
      repeat (l) drv(1'b0);
    end
  endtask

  task automatic model_clear();
    m_have      = 0;
    m_prev_push = 0;
  endtask

  // Scoreboard monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clk_in) begin
    if (reset_n && meas_valid && meas_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got period=%0d high_time=%0d, expected no result", period, high_time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk_w("period", period, e.per);
        chk_w("high_time", high_time, e.hi);
        if (e.gap != 0) chk_w("result_spacing", cyc - last_xfer, e.gap);
      end
      last_xfer = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_per;
    int e_hi;
    reset_n    = 1'b0;
    enable     = 1'b0;
    sig_in     = 1'b0;
    meas_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk_b("rst_valid", meas_valid, 1'b0);
    chk_w("rst_period", period, 0);
    chk_w("rst_high_time", high_time, 0);
    chk_b("rst_overrun", overrun, 1'b0);
    chk_b("rst_stalled", stalled, 1'b0);
    @(posedge clk_in);
    #2;
    reset_n = 1'b1;
    hold(2);

    // Basic 4/4 measurement with latency of the first result
    meas_ready = 1'b1;
    enable     = 1'b1;
    model_clear();
    hold(3);
    wave(4, 4, 1);
    drv(1'b1);
    @(negedge clk_in); chk_b("lat_valid_c1", meas_valid, 1'b0);
    drv(1'b1);
    @(negedge clk_in); chk_b("lat_valid_c2", meas_valid, 1'b0);
    drv(1'b1);
    @(negedge clk_in); chk_b("lat_valid_c3", meas_valid, 1'b1);
    drv(1'b1);
    repeat (4) drv(1'b0);
    wave(4, 4, 4);

    // Duty cycle 3/7 then minimum period
    wave(3, 7, 3);
    wave(1, 1, 4);
    hold(5);
    chk_w("queue_drained_1", q.size(), 0);
    enable = 1'b0;
    hold(3);
    model_clear();

    // Backpressure: first result held, second dropped
    meas_ready = 1'b0;
    push_en    = 0;
    enable     = 1'b1;
    hold(3);
    wave(4, 4, 1);
    wave(2, 6, 1);
    wave(5, 5, 1);
    @(negedge clk_in);
    chk_b("bp_valid_held", meas_valid, 1'b1);
    chk_b("bp_overrun", overrun, 1'b1);
    chk_w("bp_period_held", period, 8);
    chk_w("bp_high_held", high_time, 4);
    push_exp(8, 4, 0);
    meas_ready = 1'b1;
    drv(1'b0);
    meas_ready = 1'b0;
    @(negedge clk_in);
    chk_b("bp_valid_drop", meas_valid, 1'b0);
    drv(1'b0);
    e_per = m_cnt;
    e_hi  = m_hi;
    wave(3, 3, 1);
    @(negedge clk_in);
    chk_b("bp_fresh_valid", meas_valid, 1'b1);
    chk_w("bp_fresh_period", period, e_per);
    chk_w("bp_fresh_high", high_time, e_hi);
    chk_b("bp_overrun_sticky", overrun, 1'b1);
    push_exp(e_per, e_hi, 0);
    meas_ready = 1'b1;
    drv(1'b0);
    meas_ready = 1'b0;
    enable = 1'b0;
    hold(3);
    @(negedge clk_in);
    chk_b("idle_overrun_clr", overrun, 1'b0);
    chk_b("idle_valid_clr", meas_valid, 1'b0);
    drv(1'b0);
    model_clear();
    push_en = 1;

    // Timeout: stalled exactly TIMEOUT cycles after the last rise, cleared by the next rise
    meas_ready = 1'b1;
    enable     = 1'b1;
    hold(3);
    wave(4, 4, 3);
    while (m_cnt < TO + 2) drv(1'b0);
    @(negedge clk_in); chk_b("stall_before", stalled, 1'b0);
    drv(1'b0);
    @(negedge clk_in); chk_b("stall_at", stalled, 1'b1);
    drv(1'b0);
    model_clear();
    drv(1'b1);
    drv(1'b1);
    @(negedge clk_in); chk_b("stall_held", stalled, 1'b1);
    drv(1'b1);
    @(negedge clk_in); chk_b("stall_cleared", stalled, 1'b0);
    chk_b("stall_no_result", meas_valid, 1'b0);
    drv(1'b1);
    repeat (4) drv(1'b0);
    wave(4, 4, 1);
    hold(4);
    chk_w("queue_drained_2", q.size(), 0);
    enable = 1'b0;
    hold(3);
    model_clear();

    // Capture in the same cycle as a transfer
    meas_ready = 1'b0;
    push_en    = 0;
    enable     = 1'b1;
    hold(3);
    wave(4, 4, 1);
    wave(3, 7, 1);
    push_exp(8, 4, 0);
    drv(1'b1);
    drv(1'b1);
    meas_ready = 1'b1;
    drv(1'b1);
    meas_ready = 1'b0;
    @(negedge clk_in);
    chk_b("sim_valid_stays", meas_valid, 1'b1);
    chk_b("sim_no_overrun", overrun, 1'b0);
    chk_w("sim_period_new", period, 10);
    chk_w("sim_high_new", high_time, 3);
    drv(1'b0);
    push_exp(10, 3, 0);
    meas_ready = 1'b1;
    drv(1'b0);
    meas_ready = 1'b0;
    @(negedge clk_in);
    chk_b("sim_drained", meas_valid, 1'b0);
    drv(1'b0);
    enable = 1'b0;
    hold(3);
    model_clear();

    // Reset mid-measurement with a pending result
    enable = 1'b1;
    hold(3);
    wave(4, 4, 2);
    reset_n = 1'b0;
    @(negedge clk_in);
    chk_b("mid_rst_valid", meas_valid, 1'b0);
    chk_w("mid_rst_period", period, 0);
    chk_w("mid_rst_high", high_time, 0);
    chk_b("mid_rst_overrun", overrun, 1'b0);
    chk_b("mid_rst_stalled", stalled, 1'b0);
    repeat (3) drv(1'b0);
    reset_n = 1'b1;
    model_clear();
    push_en    = 1;
    meas_ready = 1'b1;
    hold(3);
    wave(4, 4, 1);
    @(negedge clk_in);
    chk_b("post_rst_one_rise", meas_valid, 1'b0);
    drv(1'b0);
    wave(4, 4, 1);
    hold(4);
    chk_w("queue_drained_3", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
# period_meter

- Measures the period and high time of a slow, asynchronous square-wave input, in `clk_in` cycles.
- Typical input is a divided clock or an external pulse train.
- Synchronizes `sig_in`, detects rising edges and counts cycles between consecutive rises.
- Presents each completed measurement on a valid/ready result port, with overrun and stall flags.

## Interface
- `WIDTH`, 32: width of the period and high-time counters and results.
- `SYNC_STAGES`, 2: synchronizer depth for `sig_in`. Minimum 2.
- `TIMEOUT`, 1000000: number of cycles without a rise before `stalled` asserts. Must be ≤ 2^WIDTH−1.
- `clk_in`  in  1  system clock. One clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; 1 = measuring, 0 = idle.
- `sig_in`  in  1  asynchronous signal being measured.
- `meas_ready`  in  1  consumer accepts the result when high in a cycle where `meas_valid` is high.
- `meas_valid`  out  1  result available.
- `period`  out  WIDTH  cycles from one detected rise to the next.
- `high_time`  out  WIDTH  cycles the synced input was high within that period.
- `overrun`  out  1  sticky; a measurement was dropped.
- `stalled`  out  1  no rise seen for `TIMEOUT` cycles.

## Operation
- **Synchronizer.** `SYNC_STAGES` flops, reset to 0. `s` is the last stage; `s_d` is `s` delayed one cycle. `rise = s & ~s_d`.
- **States:**
  - IDLE: `enable`=0.
  - ARM: wait for the first rise; no capture.
  - MEASURE: counting.
- **IDLE:**
  - `cnt`, `hi`, `meas_valid`, `overrun` and `stalled` are cleared. `period` and `high_time` hold their values.
  - When `enable`=1, go to ARM next cycle.
- **enable=0 in any state:** go to IDLE next cycle. This overrides everything else.
- **ARM:**
  - `cnt` increments each cycle.
  - On `rise`: `cnt`←1, `hi`←1, go to MEASURE, clear `stalled`.
  - On `cnt`==`TIMEOUT` with no rise: `stalled`←1, `cnt`←0, stay in ARM.
- **MEASURE, no rise:**
  - `cnt`←`cnt`+1.
  - `hi`←`hi`+`s`.
- **MEASURE, on rise (capture):**
  - Result is `period`=`cnt`, `high_time`=`hi`, using the register values in the rise cycle.
  - Then `cnt`←1, `hi`←1.
  - A rise takes priority over the timeout check.
- **MEASURE timeout:** `cnt`==`TIMEOUT` with no rise → `stalled`←1, `cnt`←0, go to ARM. No result is produced.
- **Resulting range:**
  - Measured period is 2..`TIMEOUT`.
  - `high_time` is 1..`period`−1 for a clean square wave.
- **Result handshake:**
  - A transfer occurs when `meas_valid`=1 and `meas_ready`=1.
  - Capture with `meas_valid`=0: load `period`/`high_time`, `meas_valid`←1.
  - Capture in a transfer cycle: load the new result, `meas_valid` stays 1.
  - Capture while `meas_valid`=1 with no transfer: the new result is dropped, the old one is held, `overrun`←1.
  - Transfer without capture: `meas_valid`←0 next cycle.
  - `period` and `high_time` are stable while `meas_valid`=1.
- **Flag clearing:**
  - `overrun` clears only in IDLE or on reset.
  - `stalled` clears on the next rise, in IDLE, or on reset.
- **Counter width:** counters are unsigned WIDTH bits. `TIMEOUT` bounds `cnt`, so no wrap occurs.

## Timing
- **Reset:** reset_n=0 asynchronously forces IDLE and clears the synchronizer, `cnt`, `hi` and all outputs (`meas_valid`, `period`, `high_time`, `overrun`, `stalled` = 0). This applies mid-measurement and mid-handshake.
- **Latency:**
  - `sig_in` first sampled high at edge E → `rise` during the cycle after edge E+`SYNC_STAGES`−1.
  - `meas_valid`/`period` update at edge E+`SYNC_STAGES`.
- **Steady state:** with `meas_ready` held 1 and a period-P input, `meas_valid` is a 1-cycle pulse every P cycles.
- **First result:** appears at the second detected rise after `enable` rises.
- **Stall detection:** `stalled` rises `TIMEOUT` cycles after the last rise, or after entering ARM.
- **Glitches:** pulses on `sig_in` shorter than one `clk_in` period may be missed. This is by design.

## Test plan
- **Reset:** reset_n low for 3 cycles during MEASURE with `meas_valid`=1 → all outputs 0 immediately. After release, no `meas_valid` until two rises have been seen.
- **Basic measurement:** `enable`=1, `meas_ready`=1, `sig_in` period 8 (4 high, 4 low).
  - First `meas_valid` pulse carries `period`=8, `high_time`=4.
  - Repeats every 8 cycles.
  - `meas_valid` appears 2 cycles after the second input rise (`SYNC_STAGES`=2).
- **Duty cycle and minimum period:**
  - `sig_in` 3 high / 7 low → `period`=10, `high_time`=3.
  - Toggling every cycle → `period`=2, `high_time`=1.
- **Backpressure:** `meas_ready`=0 across two captures (period 8).
  - First result is held, `overrun`=1.
  - One-cycle `meas_ready` → `meas_valid` drops the next cycle.
  - The next capture loads fresh data and `overrun` stays 1.
  - `enable`=0 → `overrun`=0.
- **Timeout:** `TIMEOUT`=100, `sig_in` held low after one period.
  - `stalled`=1 exactly 100 cycles after the last rise, and the block returns to ARM.
  - When toggling resumes, `stalled` clears on the first rise.
  - The next `meas_valid` comes at the second rise.
- **Simultaneous capture and transfer:** capture in the same cycle `meas_ready`=1 with `meas_valid`=1 → new values loaded, `meas_valid` stays 1, `overrun` stays 0.
